// File: rtl/hazard_scoreboard.sv
// Hazard detection for a 5-stage pipeline with a multi-cycle multiplier.
// Combinational stall/flush control plus a small multiply tracking FSM.
module hazard_scoreboard #(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        IF_ID_uses_rt,
  input  logic [4:0]  IF_ID_rd,
  input  logic        IF_ID_reg_write,
  input  logic        IF_ID_is_mul,
  input  logic        ID_EX_mem_read,
  input  logic [4:0]  ID_EX_rt,
  input  logic        MEM_WB_reg_write,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        IF_ID_write,
  output logic        ID_EX_bubble,
  output logic        IF_ID_flush,
  output logic        mul_busy,
  output logic        mul_wb_valid,
  output logic [4:0]  mul_wb_rd,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);

  state_t      state_q;
  logic [4:0]  pend_rd_q;
  logic [3:0]  cnt_q;
  logic [15:0] stall_cnt_q;

  logic load_use;
  logic raw_hit;
  logic waw_hit;
  logic mul_hazard;
  logic stall;
  logic accept;

  // Hazard terms; a pending rd of 0 never conflicts.
  always_comb begin
    load_use = ID_EX_mem_read && (ID_EX_rt != 5'd0) &&
               ((ID_EX_rt == IF_ID_rs) ||
                (IF_ID_uses_rt && (ID_EX_rt == IF_ID_rt)));
    raw_hit  = (pend_rd_q != 5'd0) &&
               ((pend_rd_q == IF_ID_rs) ||
                (IF_ID_uses_rt && (pend_rd_q == IF_ID_rt)));
    waw_hit  = (pend_rd_q != 5'd0) && IF_ID_reg_write &&
               (IF_ID_rd == pend_rd_q);
    mul_hazard = (state_q != IDLE) &&
                 (raw_hit || waw_hit || IF_ID_is_mul);
    stall  = (load_use || mul_hazard) && !branch_taken;
    accept = (state_q == IDLE) && IF_ID_is_mul && !stall && !branch_taken;
  end

  // Pipeline control and multiply write-back outputs.
  always_comb begin
    pc_write     = !stall;
    IF_ID_write  = !stall;
    ID_EX_bubble = stall;
    IF_ID_flush  = branch_taken;
    mul_busy     = (state_q != IDLE);
    mul_wb_valid = (state_q == WB) && !MEM_WB_reg_write;
    mul_wb_rd    = mul_wb_valid ? pend_rd_q : 5'd0;
    stall_count  = stall_cnt_q;
  end

  // Multiply tracker: accept, count down latency, wait for write-back slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_rd_q <= 5'd0;
      cnt_q     <= 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= BUSY;
            pend_rd_q <= IF_ID_rd;
            cnt_q     <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= WB;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WB: begin
          if (!MEM_WB_reg_write) begin
            state_q   <= IDLE;
            pend_rd_q <= 5'd0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Saturating stall cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

endmodule
